hdmi_video_timing: RTL and testbench

Pixel-domain video timing generator for the HDMI output path. It runs on the 74.25 MHz pixel clock, which is derived from the 371.25 MHz serial clock of the HDMI PLL, and takes that PLL's raw `lock` output. It holds all video outputs idle until lock has been stable for a programmable settle time, then produces 1280x720@60 HSYNC/VSYNC/DE, pixel coordinates and an early pixel-fetch request for the frame-buffer reader.

---
 rtl/hdmi_video_timing.sv | 188 ++++++++++++++++++
 tb/tb_hdmi_video_timing.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_video_timing.sv
// Pixel-clock video timing generator: waits for a settled PLL lock, then emits
// HSYNC/VSYNC/DE, pixel coordinates and an early fetch request.
module hdmi_video_timing #(
  parameter int unsigned H_ACTIVE  = 1280,
  parameter int unsigned H_FP      = 110,
  parameter int unsigned H_SYNC    = 40,
  parameter int unsigned H_BP      = 220,
  parameter int unsigned V_ACTIVE  = 720,
  parameter int unsigned V_FP      = 5,
  parameter int unsigned V_SYNC    = 5,
  parameter int unsigned V_BP      = 20,
  parameter logic        HS_POL    = 1'b1,
  parameter logic        VS_POL    = 1'b1,
  parameter int unsigned LOCK_WAIT = 1024,
  parameter int unsigned PREFETCH  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lock,
  output logic        running,
  output logic        req,
  output logic        hs,
  output logic        vs,
  output logic        de,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        frame_start
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] HLast   = 12'(HTotal - 1);
  localparam logic [11:0] HAct    = 12'(H_ACTIVE);
  localparam logic [11:0] HsStart = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HsEnd   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VLast   = 11'(VTotal - 1);
  localparam logic [10:0] VAct    = 11'(V_ACTIVE);
  localparam logic [10:0] VsStart = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VsEnd   = 11'(V_ACTIVE + V_FP + V_SYNC);

  localparam int unsigned SettleW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(LOCK_WAIT - 1);

  typedef enum logic [1:0] {StWaitLock, StSettle, StRun} state_e;

  state_e             state_q, state_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic               lock_meta_q, lock_s_q;
  logic               advance;

  logic [11:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;

  logic        de_e_q, hs_e_q, vs_e_q, fs_e_q;
  logic [11:0] x_e_q;
  logic [10:0] y_e_q;

  logic [PREFETCH-1:0] de_p_q, hs_p_q, vs_p_q, fs_p_q;
  logic [11:0]         x_p_q [PREFETCH];
  logic [10:0]         y_p_q [PREFETCH];

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= StWaitLock;
      settle_q    <= '0;
    end else begin
      lock_meta_q <= lock;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      settle_q    <= settle_d;
    end
  end

  // Settle counter counts consecutive synchronized-lock cycles spent in StSettle.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    unique case (state_q)
      StWaitLock: begin
        settle_d = '0;
        if (lock_s_q) state_d = StSettle;
      end
      StSettle: begin
        if (!lock_s_q) begin
          state_d  = StWaitLock;
          settle_d = '0;
        end else if (settle_q == SettleLast) begin
          state_d  = StRun;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock_s_q) state_d = StWaitLock;
      end
      default: state_d = StWaitLock;
    endcase
  end

  // Everything downstream advances only while RUN is kept; otherwise it clears,
  // so leaving RUN never flushes a partial line and re-entry starts at frame top.
  assign advance = (state_q == StRun) && lock_s_q;

  always_comb begin
    hcnt_d = '0;
    vcnt_d = '0;
    if (advance) begin
      if (hcnt_q == HLast) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == VLast) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_d = hcnt_q + 1'b1;
        vcnt_d = vcnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else begin
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !advance) begin
      de_e_q <= 1'b0;
      hs_e_q <= 1'b0;
      vs_e_q <= 1'b0;
      fs_e_q <= 1'b0;
      x_e_q  <= '0;
      y_e_q  <= '0;
    end else begin
      de_e_q <= (hcnt_q < HAct) && (vcnt_q < VAct);
      hs_e_q <= (hcnt_q >= HsStart) && (hcnt_q < HsEnd);
      vs_e_q <= (vcnt_q >= VsStart) && (vcnt_q < VsEnd);
      fs_e_q <= (hcnt_q == '0) && (vcnt_q == '0);
      x_e_q  <= ((hcnt_q < HAct) && (vcnt_q < VAct)) ? hcnt_q : '0;
      y_e_q  <= ((hcnt_q < HAct) && (vcnt_q < VAct)) ? vcnt_q : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !advance) begin
      de_p_q <= '0;
      hs_p_q <= '0;
      vs_p_q <= '0;
      fs_p_q <= '0;
      for (int i = 0; i < PREFETCH; i++) begin
        x_p_q[i] <= '0;
        y_p_q[i] <= '0;
      end
    end else begin
      de_p_q[0] <= de_e_q;
      hs_p_q[0] <= hs_e_q;
      vs_p_q[0] <= vs_e_q;
      fs_p_q[0] <= fs_e_q;
      x_p_q[0]  <= x_e_q;
      y_p_q[0]  <= y_e_q;
      for (int i = 1; i < PREFETCH; i++) begin
        de_p_q[i] <= de_p_q[i-1];
        hs_p_q[i] <= hs_p_q[i-1];
        vs_p_q[i] <= vs_p_q[i-1];
        fs_p_q[i] <= fs_p_q[i-1];
        x_p_q[i]  <= x_p_q[i-1];
        y_p_q[i]  <= y_p_q[i-1];
      end
    end
  end

  // Sync flags are held active-high internally; polarity is applied at the pins.
  assign running     = (state_q == StRun);
  assign req         = de_e_q;
  assign de          = de_p_q[PREFETCH-1];
  assign hs          = hs_p_q[PREFETCH-1] ^ ~HS_POL;
  assign vs          = vs_p_q[PREFETCH-1] ^ ~VS_POL;
  assign frame_start = fs_p_q[PREFETCH-1];
  assign x           = x_p_q[PREFETCH-1];
  assign y           = y_p_q[PREFETCH-1];

endmodule

// File: tb/tb_hdmi_video_timing.sv
// Directed bench: a small-geometry instance for full-frame behaviour and a
// default-geometry instance for idle, startup latency and line timing.
module tb_hdmi_video_timing;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  logic        s_rst, s_lock, s_running, s_req, s_hs, s_vs, s_de, s_fs;
  logic [11:0] s_x;
  logic [10:0] s_y;
  logic        d_rst, d_lock, d_running, d_req, d_hs, d_vs, d_de, d_fs;
  logic [11:0] d_x;
  logic [10:0] d_y;

  hdmi_video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .LOCK_WAIT(4), .PREFETCH(2)
  ) u_small (
    .clk(clk), .rst(s_rst), .lock(s_lock), .running(s_running), .req(s_req),
    .hs(s_hs), .vs(s_vs), .de(s_de), .x(s_x), .y(s_y), .frame_start(s_fs)
  );

  hdmi_video_timing u_dflt (
    .clk(clk), .rst(d_rst), .lock(d_lock), .running(d_running), .req(d_req),
    .hs(d_hs), .vs(d_vs), .de(d_de), .x(d_x), .y(d_y), .frame_start(d_fs)
  );

  function automatic bit s_idle();
    return !s_running && !s_req && !s_hs && !s_vs && !s_de && s_x == 0 && s_y == 0 && !s_fs;
  endfunction

  function automatic bit d_idle();
    return !d_running && !d_req && !d_hs && !d_vs && !d_de && d_x == 0 && d_y == 0 && !d_fs;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s_rst = 1'b1; d_rst = 1'b1; s_lock = 1'b0; d_lock = 1'b0;
    step(); step();
    n_total++;
    if (s_idle() !== 1'b1) $display("FAIL reset_small_idle: got de=%b hs=%b running=%b, expected idle",
                                    s_de, s_hs, s_running);
    else n_pass++;
    n_total++;
    if (d_idle() !== 1'b1) $display("FAIL reset_default_idle: got de=%b hs=%b running=%b, expected idle",
                                    d_de, d_hs, d_running);
    else n_pass++;
    s_rst = 1'b0; d_rst = 1'b0;
  endtask

  task automatic test_idle_lock_low();
    int bad_s = 0;
    int bad_d = 0;
    repeat (5000) begin
      step();
      if (!s_idle()) bad_s++;
      if (!d_idle()) bad_d++;
    end
    n_total++;
    if (bad_s !== 0) $display("FAIL idle_small: got %0d non-idle cycles, expected 0", bad_s);
    else n_pass++;
    n_total++;
    if (bad_d !== 0) $display("FAIL idle_default: got %0d non-idle cycles, expected 0", bad_d);
    else n_pass++;
    n_total++;
    if ({d_hs, d_vs} !== 2'b00) $display("FAIL idle_sync_levels: got hs=%b vs=%b, expected 0 0",
                                         d_hs, d_vs);
    else n_pass++;
  endtask

  task automatic test_default_line();
    int t, r, c0, len, f, rise1, w;
    r = -1; c0 = -1; len = 0;
    d_lock = 1'b1;
    t = cyc;
    for (int i = 0; i < 1100 && r < 0; i++) begin
      step();
      if (d_running) r = cyc;
    end
    n_total++;
    if (r !== t + 1027) $display("FAIL dflt_running_cycle: got %0d, expected %0d", r, t + 1027);
    else n_pass++;
    for (int i = 0; i < 10 && c0 < 0; i++) begin
      if (d_de) c0 = cyc;
      else step();
    end
    n_total++;
    if (c0 !== r + 3) $display("FAIL dflt_de_first: got %0d, expected %0d", c0, r + 3);
    else n_pass++;
    for (int i = 0; i < 2000 && d_de; i++) begin
      len++;
      step();
    end
    n_total++;
    if (len !== 1280) $display("FAIL dflt_de_length: got %0d, expected 1280", len);
    else n_pass++;
    f = cyc;
    for (int i = 0; i < 2000 && !d_hs; i++) step();
    n_total++;
    if (cyc - f !== 110) $display("FAIL dflt_hs_after_de: got %0d, expected 110", cyc - f);
    else n_pass++;
    rise1 = cyc;
    w = 0;
    for (int i = 0; i < 2000 && d_hs; i++) begin
      w++;
      step();
    end
    n_total++;
    if (w !== 40) $display("FAIL dflt_hs_width: got %0d, expected 40", w);
    else n_pass++;
    for (int i = 0; i < 2000 && !d_hs; i++) step();
    n_total++;
    if (cyc - rise1 !== 1650) $display("FAIL dflt_hs_period: got %0d, expected 1650", cyc - rise1);
    else n_pass++;
  endtask

  // Lock (or rst release) applied in cycle base; lock_s rises at base+2.
  task automatic test_startup(input int base, input string tag);
    int run_f = -1;
    int req_f = -1;
    int de_f  = -1;
    for (int i = 0; i < 40 && de_f < 0; i++) begin
      step();
      if (s_running && run_f < 0) run_f = cyc;
      if (s_req && req_f < 0) req_f = cyc;
      if (s_de) de_f = cyc;
    end
    n_total++;
    if (run_f !== base + 7) $display("FAIL %s_running_cycle: got %0d, expected %0d", tag, run_f, base + 7);
    else n_pass++;
    n_total++;
    if (req_f !== base + 8) $display("FAIL %s_req_cycle: got %0d, expected %0d", tag, req_f, base + 8);
    else n_pass++;
    n_total++;
    if (de_f !== base + 10) $display("FAIL %s_de_cycle: got %0d, expected %0d", tag, de_f, base + 10);
    else n_pass++;
    n_total++;
    if (s_fs !== 1'b1) $display("FAIL %s_frame_start: got %b, expected 1", tag, s_fs);
    else n_pass++;
    n_total++;
    if ({s_x, s_y} !== 23'd0) $display("FAIL %s_first_xy: got x=%0d y=%0d, expected 0 0", tag, s_x, s_y);
    else n_pass++;
  endtask

  // Starts on the first active pixel of a frame; expects H_TOTAL=14, V_TOTAL=7.
  task automatic test_frame(input int nframes, input string tag);
    int m_de = 0, m_x = 0, m_y = 0, m_hs = 0, m_vs = 0, m_fs = 0, m_req = 0, n_fs = 0;
    for (int d = 0; d < nframes * 98; d++) begin
      int h, v, h2, v2;
      logic e_de, e_req;
      h = d % 14; v = (d / 14) % 7;
      h2 = (d + 2) % 14; v2 = ((d + 2) / 14) % 7;
      e_de  = (h < 8) && (v < 4);
      e_req = (h2 < 8) && (v2 < 4);
      if (s_de !== e_de) m_de++;
      if (s_req !== e_req) m_req++;
      if (s_x !== (e_de ? 12'(h) : 12'd0)) m_x++;
      if (s_y !== (e_de ? 11'(v) : 11'd0)) m_y++;
      if (s_hs !== ((h >= 10) && (h < 12))) m_hs++;
      if (s_vs !== (v == 5)) m_vs++;
      if (s_fs !== (d % 98 == 0)) m_fs++;
      if (s_fs === 1'b1) n_fs++;
      step();
    end
    n_total++;
    if (m_de !== 0) $display("FAIL %s_de_pattern: got %0d bad cycles, expected 0", tag, m_de);
    else n_pass++;
    n_total++;
    if (m_req !== 0) $display("FAIL %s_req_pattern: got %0d bad cycles, expected 0", tag, m_req);
    else n_pass++;
    n_total++;
    if (m_x !== 0) $display("FAIL %s_x_pattern: got %0d bad cycles, expected 0", tag, m_x);
    else n_pass++;
    n_total++;
    if (m_y !== 0) $display("FAIL %s_y_pattern: got %0d bad cycles, expected 0", tag, m_y);
    else n_pass++;
    n_total++;
    if (m_hs !== 0) $display("FAIL %s_hs_pattern: got %0d bad cycles, expected 0", tag, m_hs);
    else n_pass++;
    n_total++;
    if (m_vs !== 0) $display("FAIL %s_vs_pattern: got %0d bad cycles, expected 0", tag, m_vs);
    else n_pass++;
    n_total++;
    if (m_fs !== 0) $display("FAIL %s_fs_pattern: got %0d bad cycles, expected 0", tag, m_fs);
    else n_pass++;
    n_total++;
    if (n_fs !== nframes) $display("FAIL %s_fs_count: got %0d, expected %0d", tag, n_fs, nframes);
    else n_pass++;
  endtask

  task automatic test_lock_loss();
    bit found = 1'b0;
    int bad = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (s_de && s_x == 3 && s_y == 2) found = 1'b1;
      else step();
    end
    n_total++;
    if (found !== 1'b1) $display("FAIL loss_find_pixel: got none, expected x=3 y=2");
    else n_pass++;
    s_lock = 1'b0;
    step(); step(); step();
    n_total++;
    if (s_idle() !== 1'b1) $display("FAIL loss_idle_by_3: got de=%b x=%0d running=%b, expected idle",
                                    s_de, s_x, s_running);
    else n_pass++;
    repeat (10) begin
      step();
      if (!s_idle()) bad++;
    end
    n_total++;
    if (bad !== 0) $display("FAIL loss_stays_idle: got %0d non-idle cycles, expected 0", bad);
    else n_pass++;
    s_lock = 1'b1;
    test_startup(cyc, "relock");
  endtask

  task automatic test_glitch();
    int t2, run_f;
    run_f = -1;
    s_lock = 1'b0;
    repeat (8) step();
    t2 = cyc;
    s_lock = 1'b1;
    repeat (4) step();
    s_lock = 1'b0;
    step();
    s_lock = 1'b1;
    for (int i = 0; i < 40 && run_f < 0; i++) begin
      step();
      if (s_running) run_f = cyc;
    end
    n_total++;
    if (run_f !== t2 + 12) $display("FAIL glitch_running_cycle: got %0d, expected %0d", run_f, t2 + 12);
    else n_pass++;
  endtask

  task automatic test_rst_run();
    repeat (30) step();
    s_rst = 1'b1;
    step();
    n_total++;
    if (s_idle() !== 1'b1) $display("FAIL rst_run_idle: got de=%b running=%b req=%b, expected idle",
                                    s_de, s_running, s_req);
    else n_pass++;
    s_rst = 1'b0;
    test_startup(cyc, "rst");
    test_frame(1, "rst");
  endtask

  initial begin
    test_reset();
    test_idle_lock_low();
    test_default_line();
    s_lock = 1'b1;
    test_startup(cyc, "start");
    test_frame(2, "start");
    test_lock_loss();
    test_glitch();
    test_rst_run();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "timeout");
  end

endmodule
